// File: rtl/iob_rom_csrs_ctrl.sv
// IOb subordinate front end for a boot ROM plus a small CSR bank (version, error,
// timeout, access counter), with in-order pipelined ROM reads and a read timeout.
module iob_rom_csrs_ctrl #(
    parameter int          DATA_W     = 32,
    parameter int          ROM_ADDR_W = 10,
    parameter int          ADDR_W     = ROM_ADDR_W + 3,
    parameter int          MAX_OUT    = 2,
    parameter int          TIMEOUT_W  = 8,
    parameter logic [15:0] VERSION    = 16'h0081
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_i,
    input  logic                  iob_valid_i,
    input  logic [ADDR_W-1:0]     iob_addr_i,
    input  logic [DATA_W-1:0]     iob_wdata_i,
    input  logic [DATA_W/8-1:0]   iob_wstrb_i,
    output logic                  iob_ready_o,
    output logic                  iob_rvalid_o,
    output logic [DATA_W-1:0]     iob_rdata_o,
    output logic                  rom_ren_o,
    output logic [ROM_ADDR_W-1:0] rom_raddr_o,
    input  logic                  rom_rready_i,
    input  logic                  rom_rvalid_i,
    input  logic [DATA_W-1:0]     rom_rdata_i
);

    localparam int PEND_W = $clog2(MAX_OUT + 1);
    localparam int DROP_W = 8;
    localparam logic [ADDR_W-1:0] CSR_BASE = ADDR_W'(1) << (ROM_ADDR_W + 2);

    logic [PEND_W-1:0]    pending_q;
    logic [PEND_W-1:0]    pending_nxt;
    logic [DROP_W-1:0]    drop_q;
    logic [TIMEOUT_W-1:0] idle_cnt_q;
    logic [TIMEOUT_W-1:0] timeout_q;
    logic [1:0]           err_q;
    logic [DATA_W-1:0]    access_cnt_q;
    logic [DATA_W-1:0]    csr_rdata;

    logic                 is_read;
    logic                 rom_hit;
    logic [ADDR_W-1:0]    csr_off;
    logic                 pend_full;
    logic                 rom_rd;
    logic                 acc;
    logic                 rom_acc;
    logic                 csr_rd_acc;
    logic                 wr_acc;
    logic                 rom_wr_err;
    logic                 to_wr;
    logic                 err_rd;
    logic                 drop_rsp;
    logic                 rom_rsp;
    logic                 to_fire;
    logic                 unused_bits;

    assign is_read   = ~|iob_wstrb_i;
    assign rom_hit   = iob_addr_i < CSR_BASE;
    assign csr_off   = (iob_addr_i - CSR_BASE) >> 2;
    assign pend_full = pending_q >= PEND_W'(MAX_OUT);
    assign rom_rd    = iob_valid_i & rom_hit & is_read;

    // CSR accesses and writes wait for an empty pipe so responses stay in order
    assign rom_ren_o   = cke_i & rom_rd & ~pend_full;
    assign iob_ready_o = cke_i & (rom_rd ? (rom_rready_i & ~pend_full) : (pending_q == '0));
    assign rom_raddr_o = iob_addr_i[ROM_ADDR_W+1:2];

    assign acc        = iob_valid_i & iob_ready_o;
    assign rom_acc    = acc & rom_hit & is_read;
    assign csr_rd_acc = acc & ~rom_hit & is_read;
    assign wr_acc     = acc & ~is_read;
    assign rom_wr_err = wr_acc & rom_hit;
    assign to_wr      = wr_acc & ~rom_hit & (csr_off == ADDR_W'(2));
    assign err_rd     = csr_rd_acc & (csr_off == ADDR_W'(1));

    // Responses to reads that already timed out are swallowed
    assign drop_rsp = rom_rvalid_i & (drop_q != '0);
    assign rom_rsp  = rom_rvalid_i & (drop_q == '0) & (pending_q != '0);
    assign to_fire  = (timeout_q != '0) & (pending_q != '0) & ~rom_rvalid_i
                    & (idle_cnt_q == timeout_q);

    assign pending_nxt = pending_q + PEND_W'(rom_acc) - PEND_W'(rom_rsp | to_fire);

    assign unused_bits = ^{iob_wdata_i, iob_wstrb_i};

    always_comb begin
        csr_rdata = '0;
        if (csr_off == ADDR_W'(0))
            csr_rdata = {{(DATA_W-16){1'b0}}, VERSION};
        else if (csr_off == ADDR_W'(1))
            csr_rdata = DATA_W'(err_q);
        else if (csr_off == ADDR_W'(2))
            csr_rdata = DATA_W'(timeout_q);
        else if (csr_off == ADDR_W'(3))
            csr_rdata = access_cnt_q;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            pending_q    <= '0;
            drop_q       <= '0;
            idle_cnt_q   <= '0;
            timeout_q    <= '1;
            err_q        <= '0;
            access_cnt_q <= '0;
            iob_rvalid_o <= 1'b0;
            iob_rdata_o  <= '0;
        end else if (cke_i) begin
            pending_q <= pending_nxt;

            if (to_fire)
                drop_q <= drop_q + DROP_W'(1);
            else if (drop_rsp)
                drop_q <= drop_q - DROP_W'(1);

            // Counts cycles of the current idle run, the present one included
            if (pending_nxt == '0)
                idle_cnt_q <= '0;
            else if (rom_rvalid_i | to_fire)
                idle_cnt_q <= TIMEOUT_W'(1);
            else
                idle_cnt_q <= idle_cnt_q + TIMEOUT_W'(1);

            iob_rvalid_o <= rom_rsp | to_fire | csr_rd_acc;
            if (rom_rsp)
                iob_rdata_o <= rom_rdata_i;
            else if (to_fire)
                iob_rdata_o <= '0;
            else if (csr_rd_acc)
                iob_rdata_o <= csr_rdata;

            // Error sets are applied after the read-clear so a same-cycle event survives
            err_q <= (err_q & ~{2{err_rd}}) | {to_fire, rom_wr_err};

            if (rom_acc && (access_cnt_q != '1))
                access_cnt_q <= access_cnt_q + DATA_W'(1);

            for (int i = 0; i < TIMEOUT_W; i++) begin
                if (to_wr && iob_wstrb_i[i/8])
                    timeout_q[i] <= iob_wdata_i[i];
            end
        end
    end

endmodule

// File: tb/tb_iob_rom_csrs_ctrl.sv
// Bench for iob_rom_csrs_ctrl: directed scenarios pinned by literals, then random
// traffic against a transaction-level model with a bench-side ROM.
module tb_iob_rom_csrs_ctrl;

    localparam int ROM_ADDR_W = 10;
    localparam int ADDR_W     = 13;
    localparam int MAX_OUT    = 2;
    localparam int TIMEOUT_W  = 8;
    localparam int CSR_BASE   = 4096;

    localparam int M_FIXED  = 0;
    localparam int M_SILENT = 1;
    localparam int M_RANDOM = 2;
    localparam int M_MANUAL = 3;

    logic              clk_i = 1'b0;
    logic              cke_i;
    logic              arst_i;
    logic              iob_valid_i;
    logic [ADDR_W-1:0] iob_addr_i;
    logic [31:0]       iob_wdata_i;
    logic [3:0]        iob_wstrb_i;
    logic              iob_ready_o;
    logic              iob_rvalid_o;
    logic [31:0]       iob_rdata_o;
    logic              rom_ren_o;
    logic [9:0]        rom_raddr_o;
    logic              rom_rready_i;
    logic              rom_rvalid_i;
    logic [31:0]       rom_rdata_i;

    always #5 clk_i = ~clk_i;

    iob_rom_csrs_ctrl #(
        .DATA_W(32), .ROM_ADDR_W(ROM_ADDR_W), .ADDR_W(ADDR_W),
        .MAX_OUT(MAX_OUT), .TIMEOUT_W(TIMEOUT_W), .VERSION(16'h0081)
    ) dut (
        .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
        .iob_valid_i(iob_valid_i), .iob_addr_i(iob_addr_i),
        .iob_wdata_i(iob_wdata_i), .iob_wstrb_i(iob_wstrb_i),
        .iob_ready_o(iob_ready_o), .iob_rvalid_o(iob_rvalid_o),
        .iob_rdata_o(iob_rdata_o), .rom_ren_o(rom_ren_o),
        .rom_raddr_o(rom_raddr_o), .rom_rready_i(rom_rready_i),
        .rom_rvalid_i(rom_rvalid_i), .rom_rdata_i(rom_rdata_i)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // behavioural model
    int          m_pend, m_drop, m_last;
    logic [1:0]  m_err;
    logic [7:0]  m_to;
    longint      m_acc;
    logic        m_rv;
    logic [31:0] m_rd;
    logic [31:0] m_q[$];

    // bench-side ROM
    typedef struct { int w; int c; } rom_ent_t;
    rom_ent_t rom_q[$];
    int       rom_mode;
    int       rom_lat;

    logic        s_ready, s_ren, s_rv;
    logic [31:0] s_rd;
    logic [31:0] rv_log[$];
    int          rv_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rom_word(input int w);
        return 32'h000000A0 + 32'(w);
    endfunction

    function automatic logic [31:0] csr_val(input int off);
        case (off)
            0: return 32'h00000081;
            1: return {30'b0, m_err};
            2: return {24'b0, m_to};
            3: return m_acc[31:0];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = 0; m_drop = 0; m_last = 0; m_err = 2'b00; m_to = 8'hFF;
        m_acc = 0; m_rv = 1'b0; m_rd = 32'h0;
        m_q.delete();
        rom_q.delete();
    endtask

    // Compare the DUT against the model for the current cycle, then advance the model
    task automatic model_cycle();
        logic hit, rd, exp_ready, exp_ren, acc, fire, n_rv;
        logic [31:0] n_rd, cval;
        int off, pend0;
        hit   = int'(iob_addr_i) < CSR_BASE;
        rd    = (iob_wstrb_i == 4'h0);
        off   = (int'(iob_addr_i) - CSR_BASE) / 4;
        pend0 = m_pend;
        exp_ren   = iob_valid_i && hit && rd && (pend0 < MAX_OUT);
        exp_ready = (iob_valid_i && hit && rd) ? (rom_rready_i && pend0 < MAX_OUT) : (pend0 == 0);
        chk("ready", iob_ready_o, exp_ready);
        chk("rom_ren", rom_ren_o, exp_ren);
        if (exp_ren) chk("rom_raddr", rom_raddr_o, iob_addr_i[11:2]);
        chk("rvalid", iob_rvalid_o, m_rv);
        if (m_rv) chk("rdata", iob_rdata_o, m_rd);

        acc  = iob_valid_i && exp_ready;
        fire = !rom_rvalid_i && pend0 > 0 && m_to != 8'h0 && (cyc - m_last) == int'(m_to);
        cval = csr_val(off);
        n_rv = 1'b0;
        n_rd = m_rd;
        if (acc) begin
            if (hit && rd) begin
                m_q.push_back(rom_word(int'(iob_addr_i[11:2])));
                if (pend0 == 0) m_last = cyc;
                m_pend++;
                if (m_acc < 64'hFFFFFFFF) m_acc++;
            end else if (rd) begin
                n_rv = 1'b1;
                n_rd = cval;
                if (off == 1) m_err = 2'b00;
            end else if (hit) begin
                m_err[0] = 1'b1;
            end else if (off == 2 && iob_wstrb_i[0]) begin
                m_to = iob_wdata_i[7:0];
            end
        end
        if (rom_rvalid_i) begin
            m_last = cyc;
            if (m_drop > 0) m_drop--;
            else if (pend0 > 0 && m_q.size() > 0) begin
                n_rv = 1'b1;
                n_rd = m_q.pop_front();
                m_pend--;
            end
        end else if (fire) begin
            m_last = cyc;
            n_rv = 1'b1;
            n_rd = 32'h0;
            if (m_q.size() > 0) void'(m_q.pop_front());
            m_pend--;
            m_drop++;
            m_err[1] = 1'b1;
        end
        m_rv = n_rv;
        m_rd = n_rd;
    endtask

    task automatic drive_rom();
        logic rv;
        if (rom_mode == M_MANUAL) return;
        rom_rready_i = (rom_mode == M_RANDOM) ? ($urandom_range(0, 3) != 0) : 1'b1;
        rv = rom_q.size() > 0 && rom_mode != M_SILENT && (cyc - rom_q[0].c) >= rom_lat;
        if (rom_mode == M_RANDOM && $urandom_range(0, 1) == 0) rv = 1'b0;
        rom_rvalid_i = rv;
        rom_rdata_i  = rv ? rom_word(rom_q[0].w) : $urandom;
    endtask

    task automatic tick();
        logic take, give;
        int   take_w;
        drive_rom();
        @(negedge clk_i);
        model_cycle();
        take    = rom_ren_o & rom_rready_i;
        take_w  = int'(rom_raddr_o);
        give    = rom_rvalid_i;
        s_ready = iob_ready_o;
        s_ren   = rom_ren_o;
        s_rv    = iob_rvalid_o;
        s_rd    = iob_rdata_o;
        if (s_rv) begin
            rv_log.push_back(s_rd);
            rv_cyc.push_back(cyc);
        end
        @(posedge clk_i);
        if (give && rom_q.size() > 0) rom_q.delete(0);
        if (take) rom_q.push_back('{take_w, cyc});
        cyc++;
        #1;
    endtask

    task automatic req(input int addr, input logic [3:0] strb, input logic [31:0] data);
        iob_valid_i = 1'b1;
        iob_addr_i  = ADDR_W'(addr);
        iob_wstrb_i = strb;
        iob_wdata_i = data;
    endtask

    task automatic idle();
        iob_valid_i = 1'b0;
        iob_wstrb_i = 4'h0;
        iob_wdata_i = $urandom;
    endtask

    // Hold the current request until accepted, bounded
    task automatic until_accepted(input string name);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!s_ready && k < 20);
        chk(name, s_ready, 1'b1);
    endtask

    task automatic csr_read(input string name, input int off, input logic [31:0] exp);
        req(CSR_BASE + off * 4, 4'h0, 32'h0);
        until_accepted({name, "_acc"});
        idle();
        tick();
        chk({name, "_rv"}, s_rv, 1'b1);
        chk(name, s_rd, exp);
    endtask

    task automatic do_reset_checks(input string name);
        chk({name, "_rv"}, iob_rvalid_o, 1'b0);
        chk({name, "_rd"}, iob_rdata_o, 32'h0);
        chk({name, "_ready"}, iob_ready_o, 1'b1);
        chk({name, "_ren"}, rom_ren_o, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        logic [31:0] fdata;
        logic busy;

        cke_i = 1'b1; arst_i = 1'b1;
        iob_valid_i = 1'b0; iob_addr_i = '0; iob_wstrb_i = 4'h0; iob_wdata_i = 32'h0;
        rom_rready_i = 1'b1; rom_rvalid_i = 1'b0; rom_rdata_i = 32'h0;
        rom_mode = M_FIXED; rom_lat = 1;
        model_reset();
        #12;
        do_reset_checks("por");
        @(negedge clk_i); arst_i = 1'b0;
        @(posedge clk_i); #1;

        // VERSION and TIMEOUT reset values
        csr_read("version", 0, 32'h00000081);
        csr_read("timeout_rst", 2, 32'h000000FF);

        // three back-to-back reads, ROM answering one cycle late
        rom_mode = M_FIXED; rom_lat = 2;
        rv_log.delete(); rv_cyc.delete();
        req(32'h0, 4'h0, 32'h0); tick(); chk("b2b_acc0", s_ready, 1'b1);
        req(32'h4, 4'h0, 32'h0); tick(); chk("b2b_acc1", s_ready, 1'b1);
        req(32'h8, 4'h0, 32'h0); tick(); chk("b2b_stall", s_ready, 1'b0);
        tick(); chk("b2b_acc2", s_ready, 1'b1);
        idle();
        repeat (6) tick();
        chk("b2b_count", rv_log.size(), 3);
        if (rv_log.size() == 3) begin
            chk("b2b_d0", rv_log[0], 32'h000000A0);
            chk("b2b_d1", rv_log[1], 32'h000000A1);
            chk("b2b_d2", rv_log[2], 32'h000000A2);
        end
        csr_read("access_cnt", 3, 32'h3);

        // write to ROM window raises ERR[0], cleared by reading
        req(32'h10, 4'hF, 32'h00001234); tick();
        chk("romwr_ready", s_ready, 1'b1);
        chk("romwr_ren", s_ren, 1'b0);
        idle(); tick();
        chk("romwr_norv", s_rv, 1'b0);
        csr_read("err_wr", 1, 32'h1);
        csr_read("err_clr", 1, 32'h0);

        // timeout with a silent ROM, then a late response that must be dropped
        req(CSR_BASE + 8, 4'b0001, 32'hFFFFFF04); until_accepted("to_wr");
        rom_mode = M_SILENT;
        req(32'h20, 4'h0, 32'h0); until_accepted("to_rd");
        idle();
        found = 0; fdata = 32'hFFFFFFFF;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (s_rv && found == 0) begin found = k; fdata = s_rd; end
        end
        chk("to_latency", found, 5);
        chk("to_data", fdata, 32'h0);
        csr_read("err_to", 1, 32'h2);
        rom_mode = M_MANUAL;
        rv_log.delete(); rv_cyc.delete();
        rom_rvalid_i = 1'b1; rom_rdata_i = 32'h0000DEAD;
        tick();
        rom_rvalid_i = 1'b0;
        repeat (3) tick();
        chk("late_dropped", rv_log.size(), 0);

        // CSR read waits behind a pending ROM read
        rom_mode = M_FIXED; rom_lat = 3;
        rv_log.delete(); rv_cyc.delete();
        req(32'h30, 4'h0, 32'h0); until_accepted("order_rom");
        req(CSR_BASE, 4'h0, 32'h0); tick();
        chk("order_blocked", s_ready, 1'b0);
        until_accepted("order_csr");
        idle(); tick();
        chk("order_count", rv_log.size(), 2);
        if (rv_log.size() == 2) begin
            chk("order_rom_d", rv_log[0], 32'h000000AC);
            chk("order_csr_d", rv_log[1], 32'h00000081);
            chk("order_gap", rv_cyc[1] - rv_cyc[0], 1);
        end

        // asynchronous reset with two reads in flight
        rom_mode = M_SILENT;
        req(32'h40, 4'h0, 32'h0); until_accepted("rst_rd0");
        req(32'h44, 4'h0, 32'h0); until_accepted("rst_rd1");
        idle();
        #2;
        arst_i = 1'b1;
        #1;
        do_reset_checks("midrst");
        model_reset();
        @(negedge clk_i); arst_i = 1'b0;
        @(posedge clk_i); #1;
        rom_mode = M_FIXED; rom_lat = 1;
        csr_read("access_after_rst", 3, 32'h0);

        // random traffic
        rom_mode = M_RANDOM; rom_lat = 1;
        busy = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (!busy) begin
                if ($urandom_range(0, 3) != 0) begin
                    int r, a;
                    logic [3:0] st;
                    r = $urandom_range(0, 9);
                    if (r < 6)       a = $urandom_range(0, 1023) * 4 + $urandom_range(0, 3);
                    else if (r < 9)  a = CSR_BASE + $urandom_range(0, 5) * 4 + $urandom_range(0, 3);
                    else             a = CSR_BASE + $urandom_range(0, 4095);
                    st = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
                    req(a, st, ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 12)) : $urandom);
                    busy = 1'b1;
                end else begin
                    idle();
                end
            end
            tick();
            if (iob_valid_i && s_ready) begin
                busy = 1'b0;
                idle();
            end
        end
        idle();
        rom_mode = M_FIXED;
        repeat (300) tick();
        chk("drain_pending", m_pend, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
